// File: rtl/inv_mixcolumns_seq.sv
// Iterative AES InvMixColumns unit.
// A 128-bit state is accepted into a work register. COLS_PER_CYCLE column
// engines transform it in place, one group of columns per RUN cycle. The
// finished state is then held on state_out until the downstream handshake.
//
// state | meaning
// IDLE  | waiting for a state, in_ready high
// RUN   | transforming work, one column group per edge
// DONE  | result on state_out, out_valid high until out_ready

module inv_mixcolumns_seq #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out,
  output logic         busy
);

  // Only 1, 2 and 4 engines divide the four columns evenly.
  generate
    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
      $error("inv_mixcolumns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  localparam int         STEPS    = 4 / COLS_PER_CYCLE;
  localparam logic [1:0] LAST_CNT = 2'(STEPS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state;
  state_t       state_nxt;
  logic [127:0] work;
  logic [127:0] work_nxt;
  logic [1:0]   cnt;
  logic         accept;
  logic         out_hs;
  logic         last_step;

  // Multiply by x in GF(2^8) modulo 0x11B.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Inverse MixColumns of one column; row 0 is the most significant byte.
  // Each byte's x2/x4/x8 chain is shared by all four coefficients.
  function automatic logic [31:0] inv_col(input logic [31:0] col);
    logic [7:0] a  [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] o0, o1, o2, o3;
    for (int r = 0; r < 4; r++) begin
      a[r]  = col[31-8*r -: 8];
      x2[r] = xtime(a[r]);
      x4[r] = xtime(x2[r]);
      x8[r] = xtime(x4[r]);
      m9[r] = x8[r] ^ a[r];
      mb[r] = x8[r] ^ x2[r] ^ a[r];
      md[r] = x8[r] ^ x4[r] ^ a[r];
      me[r] = x8[r] ^ x4[r] ^ x2[r];
    end
    o0 = me[0] ^ mb[1] ^ md[2] ^ m9[3];
    o1 = m9[0] ^ me[1] ^ mb[2] ^ md[3];
    o2 = md[0] ^ m9[1] ^ me[2] ^ mb[3];
    o3 = mb[0] ^ md[1] ^ m9[2] ^ me[3];
    return {o0, o1, o2, o3};
  endfunction

  assign accept    = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;
  assign last_step = (state == RUN) && (cnt == LAST_CNT);

  // Column engines: engine e works on column cnt*COLS_PER_CYCLE + e.
  // The 2-bit arithmetic wraps naturally; with four engines cnt stays 0.
  logic [1:0]  col_idx [COLS_PER_CYCLE];
  logic [31:0] eng_out [COLS_PER_CYCLE];

  generate
    for (genvar e = 0; e < COLS_PER_CYCLE; e++) begin : g_eng
      assign col_idx[e] = cnt * 2'(COLS_PER_CYCLE) + 2'(e);
      assign eng_out[e] = inv_col(work[32*col_idx[e] +: 32]);
    end
  endgenerate

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = RUN;
      RUN:     if (last_step) state_nxt = DONE;
      DONE:    if (out_hs)    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from the registered state.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  // Next work value: load on accept, replace the active columns in RUN.
  always_comb begin
    work_nxt = work;
    case (state)
      IDLE: begin
        if (accept) work_nxt = state_in;
      end
      RUN: begin
        for (int e = 0; e < COLS_PER_CYCLE; e++) begin
          work_nxt[32*col_idx[e] +: 32] = eng_out[e];
        end
      end
      default: work_nxt = work;
    endcase
  end

  // Work register, column counter and result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work      <= '0;
      cnt       <= '0;
      state_out <= '0;
    end else begin
      work <= work_nxt;
      if (accept) begin
        cnt <= '0;
      end else if (state == RUN) begin
        cnt <= cnt + 2'd1;
      end
      // Capture the fully transformed state on the last RUN edge so the
      // output holds steady while work is free to change later.
      if (last_step) begin
        state_out <= work_nxt;
      end
    end
  end

endmodule

// File: tb/tb_inv_mixcolumns_seq.sv
// Bench for inv_mixcolumns_seq: one instance per legal COLS_PER_CYCLE, each
// with its own driver and a scoreboard monitor, checked against a GF(2^8)
// matrix model of the forward and inverse MixColumns.

module tb_inv_mixcolumns_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // Plain shift-and-add GF(2^8) multiply modulo 0x11B.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p  = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? (({aa[6:0], 1'b0}) ^ 8'h1b) : {aa[6:0], 1'b0};
      bb = bb >> 1;
    end
    return p;
  endfunction

  // Circulant matrix product per column; base holds the first matrix row.
  function automatic logic [127:0] mix_model(input logic [127:0] s, input logic [31:0] base);
    logic [127:0] res = '0;
    logic [7:0]   a [4];
    logic [7:0]   acc;
    logic [7:0]   k;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = s[c*32+31-8*r -: 8];
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) begin
          k   = base[31-8*((j-r+4)%4) -: 8];
          acc = acc ^ gmul(k, a[j]);
        end
        res[c*32+31-8*r -: 8] = acc;
      end
    end
    return res;
  endfunction

  function automatic logic [127:0] inv_ref(input logic [127:0] s);
    return mix_model(s, 32'h0e0b0d09);
  endfunction

  function automatic logic [127:0] fwd_ref(input logic [127:0] s);
    return mix_model(s, 32'h02030101);
  endfunction

  task automatic check(input int c, input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL cols=%0d %s: actual=%h required=%h", c, name, act, req);
    end
  endtask

  task automatic fail(input int c, input string name);
    total++;
    bad++;
    $display("FAIL cols=%0d %s: actual=timeout/none required=event", c, name);
  endtask

  localparam logic [127:0] V1 = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] E1 = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] V2 = 128'h4d7ebdf8_d5d5d7d6_00000000_ffffffff;
  localparam logic [127:0] E2 = 128'h2d26314c_d4d4d4d5_00000000_ffffffff;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    localparam int C   = 1 << k;
    localparam int LAT = 4 / C;

    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] state_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] state_out;
    logic         busy;

    inv_mixcolumns_seq #(.COLS_PER_CYCLE(C)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .state_in  (state_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .state_out (state_out),
      .busy      (busy)
    );

    logic [127:0] exp_q [$];
    int           acc_q [$];
    int           last_hs = -100;
    bit           prev_ov = 1'b0;
    bit           rand_bp = 1'b0;
    bit           fin     = 1'b0;

    // Monitor: samples 1 time unit after the falling edge, i.e. the values
    // the next rising edge will see.
    initial begin
      forever begin
        @(negedge clk);
        #1;
        if (rst) begin
          prev_ov = 1'b0;
        end else begin
          if (out_valid) begin
            check(C, "in_ready_low_in_done", 128'(in_ready), 128'd0);
            if (!prev_ov) begin
              if (acc_q.size() == 0) fail(C, "out_valid_without_accept");
              else check(C, "latency", 128'(cyc - acc_q.pop_front()), 128'(LAT));
            end
            if (exp_q.size() == 0) begin
              fail(C, "unexpected_output");
            end else begin
              check(C, "state_out", state_out, exp_q[0]);
              if (out_ready) begin
                void'(exp_q.pop_front());
                last_hs = cyc + 1;
              end
            end
          end
          prev_ov = out_valid;
        end
      end
    end

    // Random backpressure during the bulk phase.
    initial begin
      forever begin
        @(negedge clk);
        if (rand_bp) out_ready = ($urandom % 4) != 0;
      end
    end

    // Present d until accepted; the expected result is queued on acceptance.
    task automatic send(input logic [127:0] d, input logic [127:0] e, input bit hold, output int acc_at);
      bit ok = 1'b0;
      acc_at   = -1;
      in_valid = 1'b1;
      state_in = d;
      for (int n = 0; n < 60; n++) begin
        if (in_ready) begin
          exp_q.push_back(e);
          acc_q.push_back(cyc + 1);
          acc_at = cyc + 1;
          ok = 1'b1;
          break;
        end
        @(negedge clk);
      end
      if (!ok) begin
        fail(C, "accept_timeout");
        in_valid = 1'b0;
      end else begin
        @(negedge clk);
        if (!hold) in_valid = 1'b0;
      end
    endtask

    task automatic wait_idle();
      bit ok = 1'b0;
      for (int n = 0; n < 300; n++) begin
        @(negedge clk);
        #2;
        if (exp_q.size() == 0 && !out_valid) begin
          ok = 1'b1;
          break;
        end
      end
      if (!ok) fail(C, "drain_timeout");
    endtask

    initial begin
      int a1, a2;
      bit seen;
      logic [127:0] orig;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      state_in  = '0;
      repeat (2) @(negedge clk);
      check(C, "rst_in_ready",  128'(in_ready),  128'd1);
      check(C, "rst_out_valid", 128'(out_valid), 128'd0);
      check(C, "rst_busy",      128'(busy),      128'd0);
      check(C, "rst_state_out", state_out,       128'd0);
      rst = 1'b0;
      @(negedge clk);

      // Known vectors.
      send(V1, E1, 1'b0, a1);
      check(C, "busy_after_accept", 128'(busy), 128'd1);
      wait_idle();
      send(V2, E2, 1'b0, a1);
      wait_idle();

      // Backpressure: hold the result for 10 cycles, try to sneak a state in.
      out_ready = 1'b0;
      send(V1, E1, 1'b0, a1);
      seen = 1'b0;
      for (int n = 0; n < 20; n++) begin
        if (out_valid) begin
          seen = 1'b1;
          break;
        end
        @(negedge clk);
      end
      if (!seen) fail(C, "bp_out_valid");
      for (int i = 0; i < 10; i++) begin
        check(C, "bp_out_valid_held", 128'(out_valid), 128'd1);
        check(C, "bp_busy",           128'(busy),      128'd1);
        if (i == 3) begin
          in_valid = 1'b1;
          state_in = {$urandom, $urandom, $urandom, $urandom};
        end
        if (i == 4) in_valid = 1'b0;
        @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      #2;
      check(C, "bp_in_ready_after_hs", 128'(in_ready),  128'd1);
      check(C, "bp_out_valid_cleared", 128'(out_valid), 128'd0);
      wait_idle();

      // Back-to-back with in_valid held high.
      orig = {$urandom, $urandom, $urandom, $urandom};
      send(orig, inv_ref(orig), 1'b1, a1);
      orig = {$urandom, $urandom, $urandom, $urandom};
      send(orig, inv_ref(orig), 1'b0, a2);
      check(C, "b2b_accept_after_hs", 128'(a2 - last_hs), 128'd1);
      check(C, "b2b_period",          128'(a2 - a1),      128'(LAT + 2));
      wait_idle();

      // Reset two cycles into RUN.
      orig = {$urandom, $urandom, $urandom, $urandom};
      send(orig, inv_ref(orig), 1'b0, a1);
      @(negedge clk);
      #2;
      rst = 1'b1;
      exp_q.delete();
      acc_q.delete();
      #1;
      check(C, "abort_out_valid", 128'(out_valid), 128'd0);
      check(C, "abort_state_out", state_out,       128'd0);
      check(C, "abort_in_ready",  128'(in_ready),  128'd1);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      send(V2, E2, 1'b0, a1);
      wait_idle();

      // Round trip through the forward model with random backpressure.
      rand_bp = 1'b1;
      for (int i = 0; i < 200; i++) begin
        orig = {$urandom, $urandom, $urandom, $urandom};
        send(fwd_ref(orig), orig, 1'b0, a1);
        if ($urandom % 3 == 0) @(negedge clk);
      end
      rand_bp = 1'b0;
      @(negedge clk);
      out_ready = 1'b1;
      wait_idle();
      fin = 1'b1;
    end
  end

  initial begin
    bit all_done = 1'b0;
    for (int n = 0; n < 60000; n++) begin
      @(negedge clk);
      if (g_dut[0].fin && g_dut[1].fin && g_dut[2].fin) begin
        all_done = 1'b1;
        break;
      end
    end
    if (!all_done) fail(0, "global_timeout");
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
